// File: rtl/hdr_exit_restart_gen_pkg.sv
// Shared definitions for the HDR Restart/Exit pattern generator: FSM states,
// pattern codes and the number of SDA toggle phases per pattern.
package hdr_exit_restart_gen_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PRE    = 3'd1,
      ST_TOGGLE = 3'd2,
      ST_SCL_HI = 3'd3,
      ST_SDA_HI = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

   localparam logic PAT_RESTART = 1'b0;
   localparam logic PAT_EXIT    = 1'b1;

   localparam int TOGGLES_RESTART = 4;
   localparam int TOGGLES_EXIT    = 7;

   // Zero-based index of the last TOGGLE phase for the selected pattern.
   function automatic logic [2:0] toggle_last(input logic sel);
      return (sel == PAT_EXIT) ? 3'(TOGGLES_EXIT - 1) : 3'(TOGGLES_RESTART - 1);
   endfunction

endpackage

// File: rtl/hdr_phase_timer.sv
// Loadable phase down-counter. Loading sets P_PHASE_CYC-1, so a phase that is
// reloaded every time expire is seen lasts exactly P_PHASE_CYC cycles.
module hdr_phase_timer #(
   parameter int P_PHASE_CYC = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic expire
);

   localparam int P_CNT_W = $clog2(P_PHASE_CYC + 1);
   localparam logic [P_CNT_W-1:0] LOAD_VAL = P_CNT_W'(P_PHASE_CYC - 1);

   logic [P_CNT_W-1:0] count;

   // Reload on request, otherwise count down and park at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= LOAD_VAL;
      end else if (count != '0) begin
         count <= count - P_CNT_W'(1);
      end
   end

   assign expire = (count == '0);

endmodule

// File: rtl/hdr_exit_restart_gen.sv
// Controller-side generator of the I3C HDR Restart and HDR Exit bus patterns.
// A rising edge on i_engine_en while idle runs one complete pattern; every
// output is a registered Moore value of the phase being entered.
module hdr_exit_restart_gen
   import hdr_exit_restart_gen_pkg::*;
#(
   parameter int P_PHASE_CYC = 4
) (
   input  logic i_sys_clk,
   input  logic i_sys_rst,
   input  logic i_engine_en,
   input  logic i_pattern_sel,
   output logic o_sclgen_scl,
   output logic o_sdahnd_sda,
   output logic o_sdahnd_pp_od,
   output logic o_busy,
   output logic o_engine_done
);

   state_t     state;
   logic       en_q;
   logic       sel_q;
   logic [2:0] tog_cnt;
   logic       start;
   logic       phase_active;
   logic       timer_load;
   logic       timer_expire;

   // Start detection and phase timer reload: every timed phase restarts the timer when it ends.
   always_comb begin
      start        = i_engine_en & ~en_q & (state == ST_IDLE);
      phase_active = (state == ST_PRE) | (state == ST_TOGGLE) |
                     (state == ST_SCL_HI) | (state == ST_SDA_HI);
      timer_load   = start | (phase_active & timer_expire);
   end

   hdr_phase_timer #(
      .P_PHASE_CYC(P_PHASE_CYC)
   ) u_phase_timer (
      .clk    (i_sys_clk),
      .rst    (i_sys_rst),
      .load   (timer_load),
      .expire (timer_expire)
   );

   // Pattern FSM; outputs are loaded with the values of the state being entered.
   always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
      if (i_sys_rst) begin
         state          <= ST_IDLE;
         en_q           <= 1'b0;
         sel_q          <= PAT_RESTART;
         tog_cnt        <= 3'd0;
         o_sclgen_scl   <= 1'b1;
         o_sdahnd_sda   <= 1'b1;
         o_sdahnd_pp_od <= 1'b0;
         o_busy         <= 1'b0;
         o_engine_done  <= 1'b0;
      end else begin
         en_q          <= i_engine_en;
         o_engine_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state          <= ST_PRE;
                  sel_q          <= i_pattern_sel;
                  tog_cnt        <= 3'd0;
                  o_sclgen_scl   <= 1'b0;
                  o_sdahnd_sda   <= 1'b1;
                  o_sdahnd_pp_od <= 1'b1;
                  o_busy         <= 1'b1;
               end
            end
            ST_PRE: begin
               if (timer_expire) begin
                  state        <= ST_TOGGLE;
                  o_sdahnd_sda <= 1'b0;
               end
            end
            ST_TOGGLE: begin
               if (timer_expire) begin
                  if (tog_cnt == toggle_last(sel_q)) begin
                     state          <= ST_SCL_HI;
                     o_sclgen_scl   <= 1'b1;
                     o_sdahnd_pp_od <= 1'b0;
                  end else begin
                     tog_cnt      <= tog_cnt + 3'd1;
                     o_sdahnd_sda <= ~o_sdahnd_sda;
                  end
               end
            end
            ST_SCL_HI: begin
               if (timer_expire) begin
                  if (sel_q == PAT_EXIT) begin
                     state        <= ST_SDA_HI;
                     o_sdahnd_sda <= 1'b1;
                  end else begin
                     state         <= ST_DONE;
                     o_busy        <= 1'b0;
                     o_engine_done <= 1'b1;
                  end
               end
            end
            ST_SDA_HI: begin
               if (timer_expire) begin
                  state         <= ST_DONE;
                  o_busy        <= 1'b0;
                  o_engine_done <= 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hdr_exit_restart_gen.sv
// Bench for hdr_exit_restart_gen: one instance with 4-cycle phases and one with
// 1-cycle phases share the stimulus; a waveform model predicts every cycle.
module tb_hdr_exit_restart_gen;

   localparam int N0 = 4;
   localparam int N1 = 1;
   localparam logic [4:0] IDLE_OUT = 5'b11000;  // {scl, sda, pp_od, busy, done}

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b0;
   logic sel = 1'b0;
   logic [1:0] scl, sda, pp_od, busy, done;

   int checks = 0;
   int passes = 0;
   int cyc    = 0;
   logic skip_inv = 1'b1;
   logic [4:0] prev_out [2] = '{IDLE_OUT, IDLE_OUT};

   int n_of [2] = '{N0, N1};
   int mk [2] = '{0, 0};
   logic msel [2] = '{1'b0, 1'b0};
   logic [4:0] mexp [2] = '{IDLE_OUT, IDLE_OUT};
   logic en_prev = 1'b0;

   int meas_done [2];
   int meas_dcnt [2];
   int meas_fall [2];
   int meas_scl_rise, meas_sda_rise, meas_pp_low, meas_scl_low;

   always #5 clk = ~clk;

   hdr_exit_restart_gen #(.P_PHASE_CYC(N0)) dut0 (
      .i_sys_clk(clk), .i_sys_rst(rst), .i_engine_en(en), .i_pattern_sel(sel),
      .o_sclgen_scl(scl[0]), .o_sdahnd_sda(sda[0]), .o_sdahnd_pp_od(pp_od[0]),
      .o_busy(busy[0]), .o_engine_done(done[0]));

   hdr_exit_restart_gen #(.P_PHASE_CYC(N1)) dut1 (
      .i_sys_clk(clk), .i_sys_rst(rst), .i_engine_en(en), .i_pattern_sel(sel),
      .o_sclgen_scl(scl[1]), .o_sdahnd_sda(sda[1]), .o_sdahnd_pp_od(pp_od[1]),
      .o_busy(busy[1]), .o_engine_done(done[1]));

   // Pattern length: PRE, toggles, SCL high, SDA high for Exit, then the done cycle.
   function automatic int wave_len(input int n, input logic s);
      int nt;
      nt = s ? 7 : 4;
      return n * (1 + nt + 1 + (s ? 1 : 0)) + 1;
   endfunction

   // Expected {scl, sda, pp_od, busy, done} at cycle k (1-based) of a pattern.
   function automatic logic [4:0] wave_at(input int n, input logic s, input int k);
      int ph;
      int nt;
      logic b;
      nt = s ? 7 : 4;
      ph = (k - 1) / n;
      if (ph == 0) return 5'b01110;
      if (ph <= nt) begin
         b = ((ph - 1) % 2) == 1;
         return {1'b0, b, 3'b110};
      end
      if (ph == nt + 1) begin
         b = ((nt - 1) % 2) == 1;
         return {1'b1, b, 3'b010};
      end
      if (s && ph == nt + 2) return 5'b11010;
      return 5'b11001;
   endfunction

   // Bus rules: SCL and SDA never move together; SDA moves under SCL high only as the STOP rise.
   function automatic logic bus_rule_ok(input logic [4:0] p, input logic [4:0] c);
      logic scl_chg, sda_chg;
      scl_chg = p[4] ^ c[4];
      sda_chg = p[3] ^ c[3];
      if (scl_chg && sda_chg) return 1'b0;
      if (sda_chg && p[4] && c[4] && !(c[3] && c[1])) return 1'b0;
      return 1'b1;
   endfunction

   // Reference model: position within the expected waveform of each instance.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         en_prev <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            mk[i]   <= 0;
            msel[i] <= 1'b0;
            mexp[i] <= IDLE_OUT;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            int   nk;
            logic ns;
            nk = mk[i];
            ns = msel[i];
            if (nk != 0) begin
               nk = (nk >= wave_len(n_of[i], ns)) ? 0 : nk + 1;
            end else if (en && !en_prev) begin
               nk = 1;
               ns = sel;
            end
            mk[i]   <= nk;
            msel[i] <= ns;
            mexp[i] <= (nk == 0) ? IDLE_OUT : wave_at(n_of[i], ns, nk);
         end
         en_prev <= en;
      end
   end

   task automatic check_val(input string name, input int got, input int exp);
      checks++;
      if (got == exp) passes++;
      else $display("[TB] FAIL %s got=%0d exp=%0d", name, got, exp);
   endtask

   task automatic check_output();
      logic [4:0] got;
      for (int i = 0; i < 2; i++) begin
         got = {scl[i], sda[i], pp_od[i], busy[i], done[i]};
         checks++;
         if (got === mexp[i]) passes++;
         else $display("[TB] FAIL model_cmp inst%0d cyc=%0d got=%b exp=%b (scl,sda,pp_od,busy,done)",
                       i, cyc, got, mexp[i]);
         if (!skip_inv) begin
            checks++;
            if (bus_rule_ok(prev_out[i], got)) passes++;
            else $display("[TB] FAIL bus_rule inst%0d cyc=%0d prev=%b now=%b", i, cyc, prev_out[i], got);
         end
         prev_out[i] = got;
      end
      skip_inv = 1'b0;
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      check_output();
   endtask

   // Runs one pattern with start sampled at cycle 0 and records edge timings.
   task automatic apply_stimulus(input logic s, input int hold, input int flip_at, input int ncyc);
      logic [4:0] lp [2];
      logic [4:0] cur;
      en = 1'b1;
      sel = s;
      meas_scl_rise = -1; meas_sda_rise = -1; meas_pp_low = -1; meas_scl_low = 0;
      for (int i = 0; i < 2; i++) begin
         meas_done[i] = -1; meas_dcnt[i] = 0; meas_fall[i] = 0;
         lp[i] = {scl[i], sda[i], pp_od[i], busy[i], done[i]};
      end
      for (int c = 1; c <= ncyc; c++) begin
         tick();
         for (int i = 0; i < 2; i++) begin
            cur = {scl[i], sda[i], pp_od[i], busy[i], done[i]};
            if (cur[0]) begin
               meas_dcnt[i]++;
               if (meas_done[i] < 0) meas_done[i] = c;
            end
            if (lp[i][3] && !cur[3] && !cur[4]) meas_fall[i]++;
            if (i == 0) begin
               if (!cur[4]) meas_scl_low++;
               if (cur[4] && !lp[i][4] && meas_scl_rise < 0) meas_scl_rise = c;
               if (cur[3] && !lp[i][3] && cur[4] && meas_sda_rise < 0) meas_sda_rise = c;
               if (!cur[2] && lp[i][2] && meas_pp_low < 0) meas_pp_low = c;
            end
            lp[i] = cur;
         end
         if (c >= hold) en = 1'b0;
         if (c == flip_at) sel = ~sel;
      end
      en = 1'b0;
   endtask

   initial begin
      int dc [2];

      // Reset state
      tick();
      tick();
      check_val("reset_out_inst0", int'({scl[0], sda[0], pp_od[0], busy[0], done[0]}), int'(IDLE_OUT));
      check_val("reset_out_inst1", int'({scl[1], sda[1], pp_od[1], busy[1], done[1]}), int'(IDLE_OUT));
      rst = 1'b0;
      repeat (3) tick();

      // Restart
      apply_stimulus(1'b0, 1, 0, 45);
      check_val("restart_done_n4", meas_done[0], 25);
      check_val("restart_done_n1", meas_done[1], 7);
      check_val("restart_falls_n4", meas_fall[0], 2);
      check_val("restart_falls_n1", meas_fall[1], 2);
      check_val("restart_scl_low_n4", meas_scl_low, 20);
      check_val("restart_scl_rise_n4", meas_scl_rise, 21);
      check_val("restart_done_cnt_n4", meas_dcnt[0], 1);
      repeat (3) tick();

      // Exit
      apply_stimulus(1'b1, 1, 0, 45);
      check_val("exit_done_n4", meas_done[0], 41);
      check_val("exit_done_n1", meas_done[1], 11);
      check_val("exit_falls_n4", meas_fall[0], 4);
      check_val("exit_falls_n1", meas_fall[1], 4);
      check_val("exit_scl_rise_n4", meas_scl_rise, 33);
      check_val("exit_sda_rise_n4", meas_sda_rise, 37);
      check_val("exit_pp_low_n4", meas_pp_low, 33);
      repeat (3) tick();

      // Pattern select changes mid-Restart
      apply_stimulus(1'b0, 1, 10, 45);
      check_val("selflip_done_n4", meas_done[0], 25);
      check_val("selflip_falls_n4", meas_fall[0], 2);
      sel = 1'b0;
      repeat (3) tick();

      // Enable held high, then released and raised again
      apply_stimulus(1'b0, 100, 0, 100);
      check_val("held_done_cnt_n4", meas_dcnt[0], 1);
      check_val("held_done_cnt_n1", meas_dcnt[1], 1);
      repeat (3) tick();
      apply_stimulus(1'b1, 1, 0, 45);
      check_val("retrigger_done_n4", meas_done[0], 41);
      repeat (3) tick();

      // Reset in cycle 10 of Exit
      en = 1'b1;
      sel = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         tick();
         en = 1'b0;
      end
      #2 rst = 1'b1;
      skip_inv = 1'b1;
      #1;
      check_val("midrst_scl", int'(scl[0]), 1);
      check_val("midrst_sda", int'(sda[0]), 1);
      check_val("midrst_busy", int'(busy[0]), 0);
      check_val("midrst_done", int'(done[0]), 0);
      tick();
      tick();
      rst = 1'b0;
      dc[0] = 0;
      dc[1] = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (done[0]) dc[0]++;
         if (done[1]) dc[1]++;
      end
      check_val("midrst_no_done_n4", dc[0], 0);
      check_val("midrst_no_done_n1", dc[1], 0);
      apply_stimulus(1'b1, 1, 0, 45);
      check_val("postrst_done_n4", meas_done[0], 41);
      check_val("postrst_done_n1", meas_done[1], 11);
      repeat (3) tick();

      // Randomized traffic with occasional asynchronous reset
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 7) == 0) en = ~en;
         if ($urandom_range(0, 3) == 0) sel = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 299) == 0) begin
            #2 rst = 1'b1;
            skip_inv = 1'b1;
            tick();
            rst = 1'b0;
         end else begin
            tick();
         end
      end
      en = 1'b0;
      repeat (60) tick();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
